single_ram_drain: RTL and testbench

//  Read-side consumer for the valid-tagged single_ram slot buffer. The writer fills slots
//  in sequence through port A, setting each slot's valid bit (bit PAYLOAD_BITS). This block

---
 rtl/single_ram_drain.sv | 102 ++++++++++
 tb/tb_single_ram_drain.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_ram_drain.sv
// Read-side drain for a valid-tagged slot RAM: polls slots in order through port B,
// streams each valid payload out and clears that slot's valid bit once it is captured.
module single_ram_drain #(
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned NUM_ADDR_BITS = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   output logic [NUM_ADDR_BITS-1:0] rd_addr,
   input  logic [PAYLOAD_BITS:0]    rd_dout,
   output logic                     clr_we,
   output logic [PAYLOAD_BITS:0]    clr_din,
   output logic [PAYLOAD_BITS-1:0]  dout,
   output logic                     dout_vld,
   input  logic                     dout_rdy,
   output logic [31:0]              drain_cnt
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_REQ  = 2'd1;
   localparam logic [1:0] RD_WAIT = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   localparam logic [NUM_ADDR_BITS-1:0] PtrOne = {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};

   logic [1:0]               state_q, state_d;
   logic [NUM_ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [PAYLOAD_BITS-1:0]  dout_q, dout_d;
   logic                     dout_vld_q, dout_vld_d;
   logic [31:0]              cnt_q, cnt_d;
   logic                     out_free;
   logic                     slot_valid;
   logic                     capture;

   // The output register can take a new entry if empty or if it drains this same cycle.
   assign out_free   = ~dout_vld_q | dout_rdy;
   assign slot_valid = rd_dout[PAYLOAD_BITS];
   assign capture    = (state_q == RD_WAIT) & slot_valid & out_free;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q & ~dout_rdy;
      case (state_q)
         IDLE: begin
            if (en) state_d = RD_REQ;
         end
         RD_REQ: begin
            state_d = en ? RD_WAIT : IDLE;
         end
         RD_WAIT: begin
            if (capture) begin
               dout_d     = rd_dout[PAYLOAD_BITS-1:0];
               dout_vld_d = 1'b1;
               ptr_d      = ptr_q + PtrOne;
               cnt_d      = cnt_q + 32'd1;
               state_d    = en ? RD_REQ : IDLE;
            end else if (slot_valid) begin
               state_d = HOLD;
            end else begin
               state_d = en ? RD_REQ : IDLE;
            end
         end
         HOLD: begin
            // Nothing is cached here; RD_REQ re-reads the slot once the output frees.
            if (!en) begin
               state_d = IDLE;
            end else if (out_free) begin
               state_d = RD_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rd_addr   = ptr_q;
   assign clr_we    = capture;
   assign clr_din   = '0;
   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign drain_cnt = cnt_q;

endmodule

// File: tb/tb_single_ram_drain.sv
// Bench for single_ram_drain: behavioural slot RAMs, a data/clear scoreboard per instance,
// and directed scenarios for drain, backpressure, wrap, async reset and read/write races.
module tb_single_ram_drain;

   logic clk;
   logic rst_n;
   logic ram_clear;
   int   n_vec;
   int   n_err;

   // Instance A: default geometry
   logic        en_a, rdy_a, wea_a;
   logic [6:0]  addra_a;
   logic [32:0] dina_a;
   logic [6:0]  rd_addr_a;
   logic [32:0] rd_dout_a;
   logic        clr_we_a;
   logic [32:0] clr_din_a;
   logic [31:0] dout_a;
   logic        vld_a;
   logic [31:0] cnt_a;
   logic [32:0] mem_a [128];
   logic [31:0] exp_d_a [$];
   logic [6:0]  exp_c_a [$];

   // Instance B: 4-slot ring, 8-bit payload
   logic        en_b, rdy_b, wea_b;
   logic [1:0]  addra_b;
   logic [8:0]  dina_b;
   logic [1:0]  rd_addr_b;
   logic [8:0]  rd_dout_b;
   logic        clr_we_b;
   logic [8:0]  clr_din_b;
   logic [7:0]  dout_b;
   logic        vld_b;
   logic [31:0] cnt_b;
   logic [8:0]  mem_b [4];
   logic [7:0]  exp_d_b [$];
   logic [1:0]  exp_c_b [$];
   int          cyc;

   single_ram_drain #(.PAYLOAD_BITS(32), .NUM_ADDR_BITS(7)) u_dut_a (
      .clk(clk), .reset(rst_n), .en(en_a), .rd_addr(rd_addr_a), .rd_dout(rd_dout_a),
      .clr_we(clr_we_a), .clr_din(clr_din_a), .dout(dout_a), .dout_vld(vld_a),
      .dout_rdy(rdy_a), .drain_cnt(cnt_a)
   );

   single_ram_drain #(.PAYLOAD_BITS(8), .NUM_ADDR_BITS(2)) u_dut_b (
      .clk(clk), .reset(rst_n), .en(en_b), .rd_addr(rd_addr_b), .rd_dout(rd_dout_b),
      .clr_we(clr_we_b), .clr_din(clr_din_b), .dout(dout_b), .dout_vld(vld_b),
      .dout_rdy(rdy_b), .drain_cnt(cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first RAM models; port A write lands last so it wins a same-address collision.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 128; i++) mem_a[i] <= '0;
         for (int i = 0; i < 4; i++) mem_b[i] <= '0;
      end else begin
         if (clr_we_a) mem_a[rd_addr_a] <= clr_din_a;
         if (wea_a) mem_a[addra_a] <= dina_a;
         if (clr_we_b) mem_b[rd_addr_b] <= clr_din_b;
         if (wea_b) mem_b[addra_b] <= dina_b;
      end
      rd_dout_a <= mem_a[rd_addr_a];
      rd_dout_b <= mem_b[rd_addr_b];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: sample late in the low phase, after inputs have settled.
   initial begin : mon_a
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (vld_a && rdy_a) begin
               if (exp_d_a.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL a_data: unexpected transfer got %0h, expected none", dout_a);
               end else begin
                  chk("a_data", dout_a, exp_d_a.pop_front());
               end
            end
            if (clr_we_a) begin
               chk("a_clr_din", clr_din_a, 0);
               if (exp_c_a.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL a_clr: unexpected clear at addr %0d, expected none", rd_addr_a);
               end else begin
                  chk("a_clr_addr", rd_addr_a, exp_c_a.pop_front());
               end
            end
         end
      end
   end

   initial begin : mon_b
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (vld_b && rdy_b) begin
               if (exp_d_b.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL b_data: unexpected transfer got %0h, expected none", dout_b);
               end else begin
                  chk("b_data", dout_b, exp_d_b.pop_front());
               end
            end
            if (clr_we_b) begin
               if (exp_c_b.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL b_clr: unexpected clear at addr %0d, expected none", rd_addr_b);
               end else begin
                  chk("b_clr_addr", rd_addr_b, exp_c_b.pop_front());
               end
            end
         end
      end
   end

   // Deterministic backpressure pattern for instance B.
   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         rdy_b = (cyc % 3) != 2;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1);
   end

   task automatic wr_a(input int addr, input logic [31:0] d);
      wea_a   = 1'b1;
      addra_a = addr[6:0];
      dina_a  = {1'b1, d};
      @(negedge clk);
      wea_a   = 1'b0;
   endtask

   task automatic wr_b(input int addr, input logic [7:0] d);
      wea_b   = 1'b1;
      addra_b = addr[1:0];
      dina_b  = {1'b1, d};
      @(negedge clk);
      wea_b   = 1'b0;
   endtask

   task automatic wait_cnt_a(input string name, input int target, input int budget);
      int n = 0;
      while (cnt_a != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, cnt_a, target);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; ram_clear = 1'b1;
      en_a = 1'b0; rdy_a = 1'b0; wea_a = 1'b0; addra_a = '0; dina_a = '0;
      en_b = 1'b0; wea_b = 1'b0; addra_b = '0; dina_b = '0;

      // Reset with enable low.
      repeat (3) @(negedge clk);
      ram_clear = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_rd_addr", rd_addr_a, 0);
      chk("rst_dout", dout_a, 0);
      chk("rst_vld", vld_a, 0);
      chk("rst_clr_we", clr_we_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_b_vld", vld_b, 0);

      // Basic drain of four preloaded slots.
      for (int i = 0; i < 4; i++) begin
         wr_a(i, 32'hA0 + i);
         exp_d_a.push_back(32'hA0 + i);
         exp_c_a.push_back(i[6:0]);
      end
      rdy_a = 1'b1;
      en_a  = 1'b1;
      wait_cnt_a("drain4_cnt", 4, 40);
      repeat (6) @(negedge clk);
      chk("drain4_repoll_addr", rd_addr_a, 4);
      chk("drain4_cnt_stable", cnt_a, 4);
      chk("drain4_vld_idle", vld_a, 0);
      chk("drain4_data_q", exp_d_a.size(), 0);
      chk("drain4_clr_q", exp_c_a.size(), 0);

      // Backpressure: second valid slot must wait in HOLD without being cleared.
      en_a = 1'b0; rdy_a = 1'b0;
      pulse_reset();
      wr_a(0, 32'hA0);
      wr_a(1, 32'hA1);
      exp_d_a.push_back(32'hA0); exp_d_a.push_back(32'hA1);
      exp_c_a.push_back(7'd0);
      en_a = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold_dout", dout_a, 32'hA0);
      chk("hold_vld", vld_a, 1);
      chk("hold_rd_addr", rd_addr_a, 1);
      chk("hold_cnt", cnt_a, 1);
      chk("hold_slot1_valid", mem_a[1][32], 1);
      exp_c_a.push_back(7'd1);
      rdy_a = 1'b1;
      wait_cnt_a("hold_release_cnt", 2, 40);
      repeat (4) @(negedge clk);
      chk("hold_slot1_cleared", mem_a[1][32], 0);
      chk("hold_data_q", exp_d_a.size(), 0);
      chk("hold_clr_q", exp_c_a.size(), 0);
      en_a = 1'b0;

      // Four-slot ring: ten entries stream through, wrapping twice.
      en_b = 1'b1;
      for (int i = 0; i < 10; i++) begin
         int w = 0;
         while (mem_b[i % 4][8] && w < 60) begin
            @(negedge clk);
            w++;
         end
         if (w >= 60) begin
            n_vec++; n_err++;
            $display("FAIL b_slot_free: slot %0d still valid, expected cleared", i % 4);
         end
         exp_d_b.push_back(8'h10 + 8'(i));
         exp_c_b.push_back(2'(i % 4));
         wr_b(i % 4, 8'h10 + 8'(i));
      end
      begin
         int n = 0;
         while (cnt_b != 10 && n < 80) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (6) @(negedge clk);
      chk("wrap_cnt", cnt_b, 10);
      chk("wrap_rd_addr", rd_addr_b, 2);
      chk("wrap_data_q", exp_d_b.size(), 0);
      chk("wrap_clr_q", exp_c_b.size(), 0);
      en_b = 1'b0;

      // Asynchronous reset while in HOLD.
      rdy_a = 1'b0;
      pulse_reset();
      wr_a(0, 32'hC0);
      wr_a(1, 32'hC1);
      exp_d_a.push_back(32'hC0);
      exp_c_a.push_back(7'd0);
      en_a = 1'b1;
      repeat (8) @(negedge clk);
      chk("arst_pre_vld", vld_a, 1);
      chk("arst_pre_addr", rd_addr_a, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", vld_a, 0);
      chk("arst_clr_we", clr_we_a, 0);
      chk("arst_rd_addr", rd_addr_a, 0);
      chk("arst_dout", dout_a, 0);
      chk("arst_cnt", cnt_a, 0);
      exp_d_a.delete();
      chk("arst_clr_q", exp_c_a.size(), 0);
      @(negedge clk);
      en_a  = 1'b0;
      rst_n = 1'b1;
      chk("arst_slot1_kept", mem_a[1][32], 1);
      wr_a(0, 32'hC2);
      exp_d_a.push_back(32'hC2); exp_d_a.push_back(32'hC1);
      exp_c_a.push_back(7'd0); exp_c_a.push_back(7'd1);
      rdy_a = 1'b1;
      en_a  = 1'b1;
      wait_cnt_a("arst_redrain_cnt", 2, 40);
      repeat (4) @(negedge clk);
      chk("arst_data_q", exp_d_a.size(), 0);
      chk("arst_clr_q_end", exp_c_a.size(), 0);

      // Writer fills slot 0 on the same edge that samples the RD_REQ read.
      en_a  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      en_a = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_d_a.push_back(32'hD0);
      exp_c_a.push_back(7'd0);
      wr_a(0, 32'hD0);
      @(negedge clk);
      chk("race_first_poll_miss", vld_a, 0);
      wait_cnt_a("race_cnt", 1, 20);
      repeat (6) @(negedge clk);
      chk("race_cnt_once", cnt_a, 1);
      chk("race_slot_cleared", mem_a[0][32], 0);
      chk("race_data_q", exp_d_a.size(), 0);
      chk("race_clr_q", exp_c_a.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
